// File: rtl/axi_lite_regfile.sv
// ---------------------------------------------------------------------------
// axi_lite_regfile
//
// AXI4-Lite slave exposing NUM_REGS word-wide registers to a bus master and
// their contents to peripheral logic. Writable slots are plain storage with
// byte-lane strobes. Read-only slots (RO_MASK) return the live status value
// from reg_in, sampled when the read address is accepted.
//
// The write address and write data channels are accepted independently. Each
// channel is held until the other one arrives. The register is committed on
// the edge where both are held, and the B response is raised at the same time.
//
// Optional feature:
//   AXI_LITE_REGFILE_SLVERR_EN  when defined, out-of-range reads/writes and
//                               writes to read-only slots answer SLVERR.
//                               When undefined, every response is OKAY.
//
// Ports:
//   aclk, areset            clock, synchronous active-high reset
//   S_AXI_LITE_aw*          write address channel (awaddr, awvalid, awready)
//   S_AXI_LITE_w*           write data channel (wdata, wstrb, wvalid, wready)
//   S_AXI_LITE_b*           write response channel (bresp, bvalid, bready)
//   S_AXI_LITE_ar*          read address channel (araddr, arvalid, arready)
//   S_AXI_LITE_r*           read data channel (rdata, rresp, rvalid, rready)
//   reg_out                 register contents, slot i at [i*DATA_WIDTH +: DATA_WIDTH],
//                           read-only slots drive 0
//   reg_in                  status values for read-only slots
//   wr_pulse                one-cycle pulse per register, aligned with the
//                           cycle its new value first appears on reg_out
// ---------------------------------------------------------------------------
module axi_lite_regfile #(
    parameter int                  ADDR_WIDTH = 6,
    parameter int                  DATA_WIDTH = 32,
    parameter int                  NUM_REGS   = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
    input  logic                           aclk,
    input  logic                           areset,

    input  logic [ADDR_WIDTH-1:0]          S_AXI_LITE_awaddr,
    input  logic                           S_AXI_LITE_awvalid,
    output logic                           S_AXI_LITE_awready,

    input  logic [DATA_WIDTH-1:0]          S_AXI_LITE_wdata,
    input  logic [DATA_WIDTH/8-1:0]        S_AXI_LITE_wstrb,
    input  logic                           S_AXI_LITE_wvalid,
    output logic                           S_AXI_LITE_wready,

    output logic [1:0]                     S_AXI_LITE_bresp,
    output logic                           S_AXI_LITE_bvalid,
    input  logic                           S_AXI_LITE_bready,

    input  logic [ADDR_WIDTH-1:0]          S_AXI_LITE_araddr,
    input  logic                           S_AXI_LITE_arvalid,
    output logic                           S_AXI_LITE_arready,

    output logic [DATA_WIDTH-1:0]          S_AXI_LITE_rdata,
    output logic [1:0]                     S_AXI_LITE_rresp,
    output logic                           S_AXI_LITE_rvalid,
    input  logic                           S_AXI_LITE_rready,

    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;

    // Register storage. Read-only slots are never written, so their storage
    // stays at reset value.
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    // Held write address / data.
    logic                  r_aw_held;
    logic                  r_w_held;
    logic [IDX_W-1:0]      r_aw_idx;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0]     r_wstrb;

    // Response beats.
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic                  r_rvalid;
    logic [1:0]            r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic [NUM_REGS-1:0]   r_wr_pulse;

    logic                  w_aw_fire;
    logic                  w_w_fire;
    logic                  w_ar_fire;
    logic                  w_commit;
    logic [IDX_W-1:0]      w_ar_idx;
    logic [NUM_REGS-1:0]   w_aw_sel;
    logic [NUM_REGS-1:0]   w_aw_wsel;
    logic [NUM_REGS-1:0]   w_ar_sel;
    logic [DATA_WIDTH-1:0] w_ar_data;
    logic [1:0]            w_bresp_next;
    logic [1:0]            w_rresp_next;
    logic                  w_unused;

    // Byte-offset address bits carry no information for word registers.
    assign w_unused = ^{S_AXI_LITE_awaddr[ADDR_LSB-1:0], S_AXI_LITE_araddr[ADDR_LSB-1:0]};

    // Ready terms are combinational so they drop in the same cycle that reset
    // is asserted and rise in the first cycle after it is released.
    assign S_AXI_LITE_awready = !r_aw_held && !r_bvalid && !areset;
    assign S_AXI_LITE_wready  = !r_w_held  && !r_bvalid && !areset;
    assign S_AXI_LITE_arready = !r_rvalid  && !areset;

    assign w_aw_fire = S_AXI_LITE_awvalid && S_AXI_LITE_awready;
    assign w_w_fire  = S_AXI_LITE_wvalid  && S_AXI_LITE_wready;
    assign w_ar_fire = S_AXI_LITE_arvalid && S_AXI_LITE_arready;
    assign w_commit  = r_aw_held && r_w_held;

    assign w_ar_idx  = S_AXI_LITE_araddr[ADDR_WIDTH-1:ADDR_LSB];

    // One-hot decode. An index at or beyond NUM_REGS matches no slot, so an
    // all-zero select vector doubles as the out-of-range indication.
    always_comb begin
        w_aw_sel = '0;
        w_ar_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_aw_sel[i] = (r_aw_idx == IDX_W'(i));
            w_ar_sel[i] = (w_ar_idx == IDX_W'(i));
        end
    end

    assign w_aw_wsel = w_aw_sel & ~RO_MASK;

    always_comb begin
        w_ar_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_ar_sel[i]) begin
                w_ar_data = RO_MASK[i] ? reg_in[i*DATA_WIDTH +: DATA_WIDTH] : r_regs[i];
            end
        end
    end

`ifdef AXI_LITE_REGFILE_SLVERR_EN
    // Writes succeed only on writable in-range slots; reads of read-only
    // slots are legitimate status reads and answer OKAY.
    assign w_bresp_next = (|w_aw_wsel) ? 2'b00 : 2'b10;
    assign w_rresp_next = (|w_ar_sel)  ? 2'b00 : 2'b10;
`else
    assign w_bresp_next = 2'b00;
    assign w_rresp_next = 2'b00;
`endif

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_aw_idx   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= 2'b00;
            r_rvalid   <= 1'b0;
            r_rresp    <= 2'b00;
            r_rdata    <= '0;
            r_wr_pulse <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_wr_pulse <= '0;

            if (w_aw_fire) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= S_AXI_LITE_awaddr[ADDR_WIDTH-1:ADDR_LSB];
            end

            if (w_w_fire) begin
                r_w_held <= 1'b1;
                r_wdata  <= S_AXI_LITE_wdata;
                r_wstrb  <= S_AXI_LITE_wstrb;
            end

            // Neither channel can be accepted while both are held, so the
            // commit never collides with a new AW/W handshake.
            if (w_commit) begin
                r_aw_held  <= 1'b0;
                r_w_held   <= 1'b0;
                r_bvalid   <= 1'b1;
                r_bresp    <= w_bresp_next;
                r_wr_pulse <= w_aw_wsel;
                for (int i = 0; i < NUM_REGS; i++) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (w_aw_wsel[i] && r_wstrb[b]) begin
                            r_regs[i][b*8 +: 8] <= r_wdata[b*8 +: 8];
                        end
                    end
                end
            end else if (r_bvalid && S_AXI_LITE_bready) begin
                r_bvalid <= 1'b0;
            end

            // The read mux looks at r_regs before this edge's commit, so a
            // read and write landing on the same edge return the old value.
            if (w_ar_fire) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_ar_data;
                r_rresp  <= w_rresp_next;
            end else if (r_rvalid && S_AXI_LITE_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    always_comb begin
        reg_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_out[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : r_regs[i];
        end
    end

    assign S_AXI_LITE_bvalid = r_bvalid;
    assign S_AXI_LITE_bresp  = r_bresp;
    assign S_AXI_LITE_rvalid = r_rvalid;
    assign S_AXI_LITE_rresp  = r_rresp;
    assign S_AXI_LITE_rdata  = r_rdata;
    assign wr_pulse          = r_wr_pulse;

endmodule

// File: doc/axi_lite_regfile.md
# axi_lite_regfile

Parametrised AXI4-Lite slave register file that generalises the single-register AXI-Lite slave to NUM_REGS word registers. It adds per-register read-only status inputs, byte-strobe writes, independent AW/W acceptance, write-strobe pulses to user logic, and optional error responses. It sits between the PS/interconnect AXI-Lite master port and peripheral control/status logic.

## Interface
- ADDR_WIDTH, 6, byte-address width; must be ≥ ADDR_LSB + clog2(NUM_REGS).
- DATA_WIDTH, 32, data width; allowed values are 32 and 64. ADDR_LSB = clog2(DATA_WIDTH/8).
- NUM_REGS, 8, number of word registers, 1..2^(ADDR_WIDTH-ADDR_LSB).
- RO_MASK, 0, NUM_REGS-bit mask. A set bit makes that register read-only (status).
- aclk  in  1  clock; all logic is on the rising edge.
- areset  in  1  reset, synchronous and active-high.
- S_AXI_LITE_awaddr/awvalid/awready  in/in/out  ADDR_WIDTH/1/1  write address channel.
- S_AXI_LITE_wdata/wstrb/wvalid/wready  in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel.
- S_AXI_LITE_bresp/bvalid/bready  out/out/in  2/1/1  write response channel.
- S_AXI_LITE_araddr/arvalid/arready  in/in/out  ADDR_WIDTH/1/1  read address channel.
- S_AXI_LITE_rdata/rresp/rvalid/rready  out/out/out/in  DATA_WIDTH/2/1/1  read data channel.
- reg_out  out  NUM_REGS*DATA_WIDTH  current register contents. Register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]. RO slots drive 0.
- reg_in  in  NUM_REGS*DATA_WIDTH  status values; only slots set in RO_MASK are used.
- wr_pulse  out  NUM_REGS  one-cycle pulse in the cycle a register's new value first appears on reg_out.

## Operation
- Decode: index = addr[ADDR_WIDTH-1:ADDR_LSB]. Low address bits are ignored. index ≥ NUM_REGS means out-of-range.
- Write, AW and W are independent:
  - awready = !aw_held && !bvalid && !areset.
  - wready = !w_held && !bvalid && !areset.
  - Each handshake latches its address or data+strobe and sets its held flag. Either channel may arrive first, or both in the same cycle.
- Write commit: on the edge where aw_held && w_held, and only then:
  - Writable in-range register: each byte lane with wstrb=1 is updated; lanes with wstrb=0 are kept.
  - wr_pulse[index] is asserted for the following cycle.
  - Both held flags clear, bvalid is set, and bresp is loaded.
- Ignored writes: RO or out-of-range writes change no state and raise no wr_pulse. wstrb=0 updates nothing but still pulses wr_pulse.
- bvalid holds until the bready handshake. No new AW/W is accepted while bvalid=1.
- Read:
  - arready = !rvalid && !areset.
  - The AR handshake registers rdata/rresp and sets rvalid.
  - rdata is the register value for writable slots, reg_in for RO slots, and 0 for out-of-range.
  - rvalid and rdata hold until the rready handshake.
- Read and write are fully independent. If a read samples a register on the same edge it is committed, the read returns the pre-write value.

## Timing
- Reset values: all registers 0; awready, wready, arready 0 while areset=1, then 1 in the first cycle after; bvalid 0, bresp 2'b00, rvalid 0, rresp 2'b00, rdata 0, wr_pulse 0. Held flags clear.
- Reset mid-transaction discards any held AW/W and any pending B/R beat. No register is modified.
- Write latency: bvalid and the new reg_out value appear 2 cycles after the later of the AW/W handshake cycles. If both handshake in cycle 0, bvalid=1 in cycle 2.
- Read latency: rvalid=1 in the cycle after the AR handshake. Back-to-back throughput is one read per 2 cycles when rready is held high.
- reg_in is sampled on the AR handshake edge; it is not re-sampled while rvalid is held.

## Configuration
- AXI_LITE_REGFILE_SLVERR_EN defined: out-of-range reads and writes return SLVERR (2'b10) on rresp/bresp. Writes to RO registers also return SLVERR.
- Macro undefined: every response is OKAY (2'b00). Out-of-range and RO writes are silently dropped, and out-of-range reads return 0.

## Test plan
- Write 0xDEADBEEF to awaddr 0x04 with wstrb 4'hF, AW and W in the same cycle -> bvalid in cycle 2 with bresp 00; reg_out slot 1 = 0xDEADBEEF; wr_pulse[1] for 1 cycle; reading 0x04 returns 0xDEADBEEF with rvalid 1 cycle after AR.
- Reg 1 = 0xDEADBEEF, then write 0x11223344 with wstrb 4'b0011 -> reg 1 = 0xDEAD3344.
- W presented 3 cycles before AW, and bready held low for 4 cycles -> one commit only; bvalid stays high; awready and wready stay 0 until the B handshake; a queued second AW is accepted in the cycle after it.
- RO_MASK bit 7 set, reg_in slot 7 = 0x12345678, write 0xFFFFFFFF to 0x1C -> no wr_pulse; read returns 0x12345678. bresp is 10 with SLVERR_EN defined and 00 without.
- Read and write to 0x30 (index 12 ≥ 8) -> rdata 0, no state change, no wr_pulse. resp is 10 with SLVERR_EN defined and 00 without.
- Assert areset for 1 cycle after the AW handshake but before W -> held AW is discarded; all registers read 0; a following W-only beat produces no bvalid until a new AW arrives.
